// File: rtl/lif_decoder_pkg.sv
// ============================================================================
// Module   : lif_decoder_pkg
// Brief    : Shared types and default widths for the LIF spike decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lif_decoder_pkg;

    localparam int DEF_WIN_W  = 8;
    localparam int DEF_RATE_W = 8;
    localparam int DEF_ISI_W  = 8;

    localparam int c_def_rate_sat = (1 << DEF_RATE_W) - 1;
    localparam int c_def_isi_sat  = (1 << DEF_ISI_W) - 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } dec_state_t;

endpackage

`default_nettype wire

// File: rtl/lif_spike_decoder_if.sv
// ============================================================================
// Module   : lif_spike_decoder_if
// Brief    : Result bus from the spike decoder to the readout logic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lif_spike_decoder_if #(
    parameter int RATE_W = lif_decoder_pkg::DEF_RATE_W,
    parameter int ISI_W  = lif_decoder_pkg::DEF_ISI_W
) ();

    logic [RATE_W-1:0] rate_out;
    logic              rate_valid;
    logic              rate_ready;
    logic              overrun;
    logic [ISI_W-1:0]  isi_out;
    logic              isi_valid;

    modport master (
        output rate_out, rate_valid, overrun, isi_out, isi_valid,
        input  rate_ready
    );

    modport slave (
        input  rate_out, rate_valid, overrun, isi_out, isi_valid,
        output rate_ready
    );

endinterface

`default_nettype wire

// File: rtl/lif_sat_counter.sv
// ============================================================================
// Module   : lif_sat_counter
// Brief    : Up-counter that sticks at all-ones; clear beats load beats inc.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lif_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_max = '1;

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (inc && (count_q != c_max)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/lif_spike_decoder.sv
// ============================================================================
// Module   : lif_spike_decoder
// Brief    : Spike-rate per window (+ optional ISI) with valid/ready result.
//            Define LIF_DECODER_ISI_EN to build the inter-spike interval path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lif_spike_decoder
    import lif_decoder_pkg::*;
#(
    parameter int WIN_W  = DEF_WIN_W,
    parameter int RATE_W = DEF_RATE_W,
    parameter int ISI_W  = DEF_ISI_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                spike_in,
    input  logic [WIN_W-1:0]    window_len,
    input  logic                clear,
    lif_spike_decoder_if.master rd
);

    localparam logic [RATE_W-1:0] c_rate_max = '1;
    localparam logic [WIN_W-1:0]  c_win_last = WIN_W'(1);

    dec_state_t        state_q, state_d;
    logic              spike_q, spike_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [RATE_W-1:0] rate_out_q, rate_out_d;
    logic              rate_valid_q, rate_valid_d;
    logic              overrun_q, overrun_d;

    logic              w_edge;
    logic              w_cnt_clr;
    logic              w_cnt_inc;
    logic [RATE_W-1:0] w_spk_cnt;
    logic [RATE_W-1:0] w_spk_next;

    assign w_edge    = spike_in & ~spike_q;
    assign w_cnt_inc = (state_q == COUNT) & w_edge;

    // Window total including an edge landing on the closing cycle itself.
    assign w_spk_next = (w_spk_cnt == c_rate_max) ? w_spk_cnt
                      : w_spk_cnt + {{(RATE_W-1){1'b0}}, w_edge};

    lif_sat_counter #(.WIDTH(RATE_W)) u_spk_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (w_cnt_clr),
        .load     (1'b0),
        .load_val ({RATE_W{1'b0}}),
        .inc      (w_cnt_inc),
        .count    (w_spk_cnt)
    );

    always_comb begin
        spike_d      = spike_in;
        state_d      = state_q;
        win_d        = win_q;
        rate_out_d   = rate_out_q;
        rate_valid_d = rate_valid_q;
        overrun_d    = overrun_q;
        w_cnt_clr    = 1'b0;

        if (rate_valid_q && rd.rate_ready) begin
            rate_valid_d = 1'b0;
        end

        if (clear) begin
            state_d      = IDLE;
            rate_out_d   = '0;
            rate_valid_d = 1'b0;
            overrun_d    = 1'b0;
            w_cnt_clr    = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    w_cnt_clr = 1'b1;
                    if (ena && (window_len != '0)) begin
                        state_d = COUNT;
                        win_d   = window_len;
                    end
                end
                COUNT: begin
                    if (!ena) begin
                        state_d   = IDLE;
                        w_cnt_clr = 1'b1;
                    end else if (win_q == c_win_last) begin
                        // Close: publish, then roll straight into the next window.
                        rate_out_d   = w_spk_next;
                        rate_valid_d = 1'b1;
                        w_cnt_clr    = 1'b1;
                        if (rate_valid_q && !rd.rate_ready) begin
                            overrun_d = 1'b1;
                        end
                        if (window_len == '0) begin
                            state_d = IDLE;
                        end else begin
                            win_d = window_len;
                        end
                    end else begin
                        win_d = win_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            spike_q      <= 1'b0;
            win_q        <= '0;
            rate_out_q   <= '0;
            rate_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            spike_q      <= spike_d;
            win_q        <= win_d;
            rate_out_q   <= rate_out_d;
            rate_valid_q <= rate_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rd.rate_out   = rate_out_q;
    assign rd.rate_valid = rate_valid_q;
    assign rd.overrun    = overrun_q;

`ifdef LIF_DECODER_ISI_EN
    logic             armed_q, armed_d;
    logic             isi_valid_q, isi_valid_d;
    logic [ISI_W-1:0] isi_out_q, isi_out_d;
    logic [ISI_W-1:0] w_isi_cnt;
    logic             w_isi_clr;
    logic             w_isi_edge;

    assign w_isi_clr  = clear | ~ena;
    assign w_isi_edge = w_edge & ~w_isi_clr;

    // Restarting at 1 on every edge makes the count equal the edge-to-edge distance.
    lif_sat_counter #(.WIDTH(ISI_W)) u_isi_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (w_isi_clr),
        .load     (w_isi_edge),
        .load_val (ISI_W'(1)),
        .inc      (ena),
        .count    (w_isi_cnt)
    );

    always_comb begin
        armed_d     = armed_q;
        isi_out_d   = isi_out_q;
        isi_valid_d = w_isi_edge & armed_q;
        if (w_isi_clr) begin
            armed_d = 1'b0;
        end else if (w_isi_edge) begin
            armed_d = 1'b1;
        end
        if (clear) begin
            isi_out_d = '0;
        end else if (w_isi_edge && armed_q) begin
            isi_out_d = w_isi_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q     <= 1'b0;
            isi_valid_q <= 1'b0;
            isi_out_q   <= '0;
        end else begin
            armed_q     <= armed_d;
            isi_valid_q <= isi_valid_d;
            isi_out_q   <= isi_out_d;
        end
    end

    assign rd.isi_out   = isi_out_q;
    assign rd.isi_valid = isi_valid_q;
`else
    assign rd.isi_out   = {ISI_W{1'b0}};
    assign rd.isi_valid = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lif_spike_decoder.sv
// ============================================================================
// Module   : tb_lif_spike_decoder
// Brief    : Self-checking bench for lif_spike_decoder against an event model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lif_spike_decoder;

    localparam int WIN_W    = 8;
    localparam int RATE_W   = 5;
    localparam int ISI_W    = 8;
    localparam int RATE_MAX = (1 << RATE_W) - 1;
    localparam int ISI_MAX  = (1 << ISI_W) - 1;
    localparam int MAXC     = 320;

    typedef struct {
        int rate_out;
        bit rate_valid;
        bit overrun;
        bit isi_valid;
        int isi_out;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             ena = 1'b0;
    logic             spike_in = 1'b0;
    logic             clear = 1'b0;
    logic [WIN_W-1:0] window_len = '0;

    int n_pass  = 0;
    int n_total = 0;

    bit sp  [0:MAXC];
    bit rdy [0:MAXC];

    lif_spike_decoder_if #(.RATE_W(RATE_W), .ISI_W(ISI_W)) rd_if ();

    lif_spike_decoder #(.WIN_W(WIN_W), .RATE_W(RATE_W), .ISI_W(ISI_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .spike_in   (spike_in),
        .window_len (window_len),
        .clear      (clear),
        .rd         (rd_if)
    );

    always #5 clk = ~clk;

    // Stream cycle 0 is the IDLE->COUNT cycle; windows cover cycles
    // [k*len+1, (k+1)*len] and close on their last cycle.
    function automatic bit edge_at(input int c);
        return (c >= 1) && sp[c] && !sp[c-1];
    endfunction

    function automatic bit ready_in(input int a, input int b);
        for (int c = a; c <= b; c++) if (rdy[c]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic exp_t model(input int t, input int len);
        exp_t e;
        int   lastq, s, prev;
        e = '{default: 0};
        lastq = (t / len) * len;
        if (lastq >= len) begin
            s = 0;
            for (int c = lastq - len + 1; c <= lastq; c++) s += int'(edge_at(c));
            e.rate_out   = (s > RATE_MAX) ? RATE_MAX : s;
            e.rate_valid = !ready_in(lastq + 1, t);
        end
        for (int q = 2 * len; q <= t; q += len)
            if (!ready_in(q - len + 1, q)) e.overrun = 1'b1;
        prev = -1;
        for (int c = 1; c <= t; c++) begin
            if (edge_at(c)) begin
                if (prev >= 0) begin
                    e.isi_out = ((c - prev) > ISI_MAX) ? ISI_MAX : (c - prev);
                    if (c == t) e.isi_valid = 1'b1;
                end
                prev = c;
            end
        end
`ifndef LIF_DECODER_ISI_EN
        e.isi_out   = 0;
        e.isi_valid = 1'b0;
`endif
        return e;
    endfunction

    task automatic clear_stim();
        for (int c = 0; c <= MAXC; c++) begin
            sp[c]  = 1'b0;
            rdy[c] = 1'b0;
        end
    endtask

    task automatic begin_stream(input int len);
        clear = 1'b1; ena = 1'b0; spike_in = 1'b0; rd_if.rate_ready = 1'b0;
        @(posedge clk); #1;
        clear = 1'b0;
        @(posedge clk); #1;
        ena = 1'b1;
        window_len = WIN_W'(len);
    endtask

    task automatic step(input int t);
        spike_in = sp[t];
        rd_if.rate_ready = rdy[t];
        @(posedge clk); #1;
    endtask

    task automatic end_stream();
        ena = 1'b0; spike_in = 1'b0; rd_if.rate_ready = 1'b0; window_len = '0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        n_total++; if (rd_if.rate_valid !== 1'b0) $display("FAIL reset_valid got %0b exp 0", rd_if.rate_valid); else n_pass++;
        n_total++; if (rd_if.rate_out !== '0) $display("FAIL reset_rate_out got %0d exp 0", rd_if.rate_out); else n_pass++;
        n_total++; if ({rd_if.overrun, rd_if.isi_valid} !== 2'b00 || rd_if.isi_out !== '0)
            $display("FAIL reset_flags got ovr=%0b iv=%0b io=%0d exp 0", rd_if.overrun, rd_if.isi_valid, rd_if.isi_out);
        else n_pass++;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_window();
        exp_t e;
        clear_stim();
        sp[2] = 1; sp[5] = 1; sp[8] = 1;
        for (int c = 0; c <= MAXC; c++) rdy[c] = 1'b1;
        begin_stream(10);
        for (int t = 0; t <= 14; t++) begin
            step(t);
            if (t == 0) continue;
            e = model(t, 10);
            n_total++; if (rd_if.rate_valid !== e.rate_valid) $display("FAIL basic_valid t=%0d got %0b exp %0b", t, rd_if.rate_valid, e.rate_valid); else n_pass++;
            n_total++; if (rd_if.rate_out !== RATE_W'(e.rate_out)) $display("FAIL basic_rate t=%0d got %0d exp %0d", t, rd_if.rate_out, e.rate_out); else n_pass++;
        end
        end_stream();
    endtask

    task automatic test_edge_cases();
        exp_t e;
        clear_stim();
        for (int c = 3; c <= 7; c++) sp[c] = 1'b1;
        sp[10] = 1'b1;
        for (int c = 0; c <= MAXC; c++) rdy[c] = 1'b1;
        begin_stream(10);
        for (int t = 0; t <= 12; t++) begin
            step(t);
            if (t == 0) continue;
            e = model(t, 10);
            n_total++; if (rd_if.rate_out !== RATE_W'(e.rate_out) || rd_if.rate_valid !== e.rate_valid)
                $display("FAIL edge_rate t=%0d got %0d/%0b exp %0d/%0b", t, rd_if.rate_out, rd_if.rate_valid, e.rate_out, e.rate_valid);
            else n_pass++;
        end
        end_stream();
    endtask

    task automatic test_saturation();
        exp_t e;
        clear_stim();
        for (int c = 1; c <= 80; c++) sp[c] = bit'(c % 2);
        for (int c = 0; c <= MAXC; c++) rdy[c] = 1'b1;
        begin_stream(80);
        for (int t = 0; t <= 81; t++) begin
            step(t);
            if (t < 79) continue;
            e = model(t, 80);
            n_total++; if (rd_if.rate_out !== RATE_W'(e.rate_out)) $display("FAIL sat_rate t=%0d got %0d exp %0d", t, rd_if.rate_out, e.rate_out); else n_pass++;
            if (t == 80) begin
                n_total++; if (rd_if.rate_out !== RATE_W'(RATE_MAX)) $display("FAIL sat_max got %0d exp %0d", rd_if.rate_out, RATE_MAX); else n_pass++;
            end
        end
        end_stream();
    endtask

    task automatic test_overrun_clear();
        exp_t e;
        clear_stim();
        for (int c = 1; c <= 8; c++) sp[c] = bit'($urandom_range(0, 1));
        sp[9] = 1'b0;
        begin_stream(4);
        for (int t = 0; t <= 9; t++) begin
            step(t);
            if (t == 0) continue;
            e = model(t, 4);
            n_total++; if (rd_if.overrun !== e.overrun || rd_if.rate_valid !== e.rate_valid)
                $display("FAIL ovr_flags t=%0d got ovr=%0b v=%0b exp ovr=%0b v=%0b", t, rd_if.overrun, rd_if.rate_valid, e.overrun, e.rate_valid);
            else n_pass++;
            n_total++; if (rd_if.rate_out !== RATE_W'(e.rate_out)) $display("FAIL ovr_rate t=%0d got %0d exp %0d", t, rd_if.rate_out, e.rate_out); else n_pass++;
        end
        clear = 1'b1; spike_in = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        n_total++; if (rd_if.rate_valid !== 1'b0 || rd_if.overrun !== 1'b0)
            $display("FAIL clear_flags got v=%0b ovr=%0b exp 0/0", rd_if.rate_valid, rd_if.overrun);
        else n_pass++;
        n_total++; if (rd_if.isi_valid !== 1'b0 || rd_if.rate_out !== '0)
            $display("FAIL clear_out got iv=%0b rate=%0d exp 0/0", rd_if.isi_valid, rd_if.rate_out);
        else n_pass++;
        end_stream();
    endtask

    task automatic test_window_len_zero();
        begin_stream(4);
        spike_in = 1'b0;
        @(posedge clk); #1;
        window_len = '0;
        for (int t = 1; t <= 4; t++) begin
            spike_in = bit'(t % 2);
            @(posedge clk); #1;
        end
        n_total++; if (rd_if.rate_out !== RATE_W'(2) || rd_if.rate_valid !== 1'b1)
            $display("FAIL wlz_close got %0d/%0b exp 2/1", rd_if.rate_out, rd_if.rate_valid);
        else n_pass++;
        rd_if.rate_ready = 1'b1;
        for (int t = 0; t < 12; t++) begin
            spike_in = bit'(t % 2);
            @(posedge clk); #1;
        end
        n_total++; if (rd_if.rate_out !== RATE_W'(2) || rd_if.rate_valid !== 1'b0)
            $display("FAIL wlz_idle got %0d/%0b exp 2/0", rd_if.rate_out, rd_if.rate_valid);
        else n_pass++;
        end_stream();
    endtask

    task automatic test_isi();
        exp_t e;
        clear_stim();
        sp[5] = 1; sp[12] = 1; sp[20] = 1;
        for (int c = 0; c <= MAXC; c++) rdy[c] = 1'b1;
        begin_stream(30);
        for (int t = 0; t <= 24; t++) begin
            step(t);
            if (t == 0) continue;
            e = model(t, 30);
            n_total++; if (rd_if.isi_valid !== e.isi_valid || rd_if.isi_out !== ISI_W'(e.isi_out))
                $display("FAIL isi t=%0d got %0b/%0d exp %0b/%0d", t, rd_if.isi_valid, rd_if.isi_out, e.isi_valid, e.isi_out);
            else n_pass++;
        end
        end_stream();
        clear_stim();
        sp[2] = 1; sp[302] = 1; sp[304] = 1;
        for (int c = 0; c <= MAXC; c++) rdy[c] = 1'b1;
        begin_stream(200);
        for (int t = 0; t <= 306; t++) begin
            step(t);
            if (t < 300) continue;
            e = model(t, 200);
            n_total++; if (rd_if.isi_valid !== e.isi_valid || rd_if.isi_out !== ISI_W'(e.isi_out))
                $display("FAIL isi_sat t=%0d got %0b/%0d exp %0b/%0d", t, rd_if.isi_valid, rd_if.isi_out, e.isi_valid, e.isi_out);
            else n_pass++;
        end
        end_stream();
    endtask

    task automatic test_random();
        exp_t e;
        int   len, pct_sp, pct_rdy;
        for (int it = 0; it < 6; it++) begin
            clear_stim();
            len     = $urandom_range(1, 12);
            pct_sp  = $urandom_range(20, 70);
            pct_rdy = (it == 0) ? 0 : $urandom_range(10, 90);
            for (int c = 1; c <= 60; c++) begin
                sp[c]  = ($urandom_range(0, 99) < pct_sp);
                rdy[c] = ($urandom_range(0, 99) < pct_rdy);
            end
            begin_stream(len);
            for (int t = 0; t <= 60; t++) begin
                step(t);
                if (t == 0) continue;
                e = model(t, len);
                n_total++; if (rd_if.rate_out !== RATE_W'(e.rate_out) || rd_if.rate_valid !== e.rate_valid || rd_if.overrun !== e.overrun)
                    $display("FAIL rand_rate it=%0d len=%0d t=%0d got %0d/%0b/%0b exp %0d/%0b/%0b", it, len, t,
                             rd_if.rate_out, rd_if.rate_valid, rd_if.overrun, e.rate_out, e.rate_valid, e.overrun);
                else n_pass++;
                n_total++; if (rd_if.isi_valid !== e.isi_valid || rd_if.isi_out !== ISI_W'(e.isi_out))
                    $display("FAIL rand_isi it=%0d t=%0d got %0b/%0d exp %0b/%0d", it, t, rd_if.isi_valid, rd_if.isi_out, e.isi_valid, e.isi_out);
                else n_pass++;
            end
            end_stream();
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        clear_stim();
        for (int c = 1; c <= 7; c++) sp[c] = bit'($urandom_range(0, 1));
        begin_stream(3);
        for (int t = 0; t <= 7; t++) begin
            step(t);
            if (t != 7) continue;
            e = model(t, 3);
            n_total++; if (rd_if.rate_valid !== e.rate_valid) $display("FAIL rstmid_pre got %0b exp %0b", rd_if.rate_valid, e.rate_valid); else n_pass++;
        end
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (rd_if.rate_valid !== 1'b0 || rd_if.overrun !== 1'b0 || rd_if.rate_out !== '0)
            $display("FAIL rstmid_async got v=%0b ovr=%0b rate=%0d exp 0", rd_if.rate_valid, rd_if.overrun, rd_if.rate_out);
        else n_pass++;
        end_stream();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ena = 1'b1; window_len = WIN_W'(2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_total++; if (rd_if.rate_valid !== 1'b0) $display("FAIL rstmid_idle1 got %0b exp 0", rd_if.rate_valid); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (rd_if.rate_valid !== 1'b1) $display("FAIL rstmid_idle2 got %0b exp 1", rd_if.rate_valid); else n_pass++;
        end_stream();
    endtask

    initial begin
        rd_if.rate_ready = 1'b0;
        test_reset();
        test_basic_window();
        test_edge_cases();
        test_saturation();
        test_overrun_clear();
        test_window_len_zero();
        test_isi();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
